// File: rtl/memory_bus_arbiter.sv
// Two-core to single-DRAM bus arbiter: round-robin grant, one packet in flight,
// range/destination/timeout error pulses.
module memory_bus_arbiter #(
  parameter int unsigned ADDR_W    = 64,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned SRC_W     = 4,
  parameter int unsigned MEM_BYTES = 65536,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c0_req_valid,
  output logic              c0_req_ready,
  input  logic              c0_req_type,
  input  logic [ADDR_W-1:0] c0_req_addr,
  input  logic [DATA_W-1:0] c0_req_payload,
  input  logic [SRC_W-1:0]  c0_req_source,
  output logic              c0_rsp_valid,
  output logic [DATA_W-1:0] c0_rsp_data,
  input  logic              c1_req_valid,
  output logic              c1_req_ready,
  input  logic              c1_req_type,
  input  logic [ADDR_W-1:0] c1_req_addr,
  input  logic [DATA_W-1:0] c1_req_payload,
  input  logic [SRC_W-1:0]  c1_req_source,
  output logic              c1_rsp_valid,
  output logic [DATA_W-1:0] c1_rsp_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_type,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_payload,
  output logic [SRC_W-1:0]  mem_req_source,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  input  logic [SRC_W-1:0]  mem_rsp_dest,
  output logic              err_range,
  output logic              err_dest,
  output logic              err_timeout
);

  localparam int unsigned CNT_W = 16;
  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(MEM_BYTES - 8);
  localparam logic [CNT_W-1:0]  CNT_LIMIT  = CNT_W'(TIMEOUT);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [1:0]        r_state;
  logic              r_rr_ptr;
  logic              r_run;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_port;
  logic              r_type;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_payload;
  logic [SRC_W-1:0]  r_src;
  logic              r_mem_req_valid;
  logic              r_c0_rsp_valid;
  logic              r_c1_rsp_valid;
  logic [DATA_W-1:0] r_c0_rsp_data;
  logic [DATA_W-1:0] r_c1_rsp_data;
  logic              r_err_range;
  logic              r_err_dest;
  logic              r_err_timeout;

  logic              w_grant;
  logic              w_accept;
  logic              w_sel_type;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_payload;
  logic [SRC_W-1:0]  w_sel_src;
  logic [1:0]        w_state_nxt;
  logic              w_rr_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_capture;
  logic [1:0]        w_rsp_nxt;
  logic              w_err_range_nxt;
  logic              w_err_dest_nxt;
  logic              w_err_timeout_nxt;

  // Grant selection; acceptance is held off while a core response pulse is out
  assign w_grant  = (c0_req_valid && c1_req_valid) ? r_rr_ptr : c1_req_valid;
  assign w_accept = r_run && (r_state == S_IDLE) && (c0_req_valid || c1_req_valid)
                    && !r_c0_rsp_valid && !r_c1_rsp_valid;
  assign c0_req_ready = w_accept && !w_grant;
  assign c1_req_ready = w_accept &&  w_grant;

  assign w_sel_type    = w_grant ? c1_req_type    : c0_req_type;
  assign w_sel_addr    = w_grant ? c1_req_addr    : c0_req_addr;
  assign w_sel_payload = w_grant ? c1_req_payload : c0_req_payload;
  assign w_sel_src     = w_grant ? c1_req_source  : c0_req_source;

  always_comb begin
    w_state_nxt       = r_state;
    w_rr_nxt          = r_rr_ptr;
    w_cnt_nxt         = r_cnt;
    w_capture         = 1'b0;
    w_rsp_nxt         = 2'b00;
    w_err_range_nxt   = 1'b0;
    w_err_dest_nxt    = 1'b0;
    w_err_timeout_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_err_dest_nxt = mem_rsp_valid;
        if (w_accept) begin
          w_rr_nxt = !w_grant;
          if (w_sel_addr > ADDR_LIMIT) begin
            w_err_range_nxt = 1'b1;
          end else begin
            w_capture   = 1'b1;
            w_state_nxt = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        w_err_dest_nxt = mem_rsp_valid;
        if (mem_req_ready) begin
          w_state_nxt = r_type ? S_IDLE : S_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      S_WAIT: begin
        if (mem_rsp_valid) begin
          if (mem_rsp_dest == r_src) begin
            w_rsp_nxt[r_port] = 1'b1;
            w_state_nxt       = S_IDLE;
          end else begin
            w_err_dest_nxt = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
          if (r_cnt + CNT_W'(1) == CNT_LIMIT) begin
            w_err_timeout_nxt = 1'b1;
            w_state_nxt       = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_rr_ptr        <= 1'b0;
      r_run           <= 1'b0;
      r_cnt           <= '0;
      r_port          <= 1'b0;
      r_type          <= 1'b0;
      r_addr          <= '0;
      r_payload       <= '0;
      r_src           <= '0;
      r_mem_req_valid <= 1'b0;
      r_c0_rsp_valid  <= 1'b0;
      r_c1_rsp_valid  <= 1'b0;
      r_c0_rsp_data   <= '0;
      r_c1_rsp_data   <= '0;
      r_err_range     <= 1'b0;
      r_err_dest      <= 1'b0;
      r_err_timeout   <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_rr_ptr        <= w_rr_nxt;
      r_run           <= 1'b1;
      r_cnt           <= w_cnt_nxt;
      r_mem_req_valid <= (w_state_nxt == S_ISSUE);
      r_c0_rsp_valid  <= w_rsp_nxt[0];
      r_c1_rsp_valid  <= w_rsp_nxt[1];
      r_err_range     <= w_err_range_nxt;
      r_err_dest      <= w_err_dest_nxt;
      r_err_timeout   <= w_err_timeout_nxt;
      if (w_capture) begin
        r_port    <= w_grant;
        r_type    <= w_sel_type;
        r_addr    <= w_sel_addr;
        r_payload <= w_sel_payload;
        r_src     <= w_sel_src;
      end
      if (w_rsp_nxt[0]) r_c0_rsp_data <= mem_rsp_data;
      if (w_rsp_nxt[1]) r_c1_rsp_data <= mem_rsp_data;
    end
  end

  assign mem_req_valid   = r_mem_req_valid;
  assign mem_req_type    = r_type;
  assign mem_req_addr    = r_addr;
  assign mem_req_payload = r_payload;
  assign mem_req_source  = r_src;
  assign c0_rsp_valid    = r_c0_rsp_valid;
  assign c1_rsp_valid    = r_c1_rsp_valid;
  assign c0_rsp_data     = r_c0_rsp_data;
  assign c1_rsp_data     = r_c1_rsp_data;
  assign err_range       = r_err_range;
  assign err_dest        = r_err_dest;
  assign err_timeout     = r_err_timeout;

endmodule

// File: doc/memory_bus_arbiter.md
MEMORY_BUS_ARBITER -- requirements
Module: memory_bus_arbiter

Interface
REQ-001 Parameter ADDR_W, default 64, byte-address width of every bus packet.
REQ-002 Parameter DATA_W, default 64, payload width; fixed at 8 bytes per packet.
REQ-003 Parameter SRC_W, default 4, width of the packet source field.
REQ-004 Parameter MEM_BYTES, default 65536, DRAM size in bytes (END_MEMORY_ADDRESS).
REQ-005 Parameter TIMEOUT, default 255, maximum read-response wait in cycles; 1..65535.
REQ-006 Port clk, in, 1, single clock; all state changes on the rising edge.
REQ-007 Port rst_n, in, 1, reset; one clock, reset asynchronous and active-low.
REQ-008 Ports cN_req_valid / cN_req_ready (N=0,1), in / out, 1 each, per-core request handshake.
REQ-009 Ports cN_req_type, in, 1, 0 = bus_read_data, 1 = bus_write_data.
REQ-010 Ports cN_req_addr / cN_req_payload / cN_req_source, in, ADDR_W / DATA_W / SRC_W, packet fields.
REQ-011 Ports cN_rsp_valid / cN_rsp_data, out, 1 / DATA_W, read response to core N, one-cycle pulse.
REQ-012 Ports mem_req_valid / mem_req_ready, out / in, 1 each, request handshake toward DRAM.
REQ-013 Ports mem_req_type / mem_req_addr / mem_req_payload / mem_req_source, out, as REQ-009/010.
REQ-014 Ports mem_rsp_valid / mem_rsp_data / mem_rsp_dest, in, 1 / DATA_W / SRC_W, DRAM read response.
REQ-015 Ports err_range / err_dest / err_timeout, out, 1 each, one-cycle error pulses.

Function
REQ-016 FSM states IDLE, ISSUE, WAIT_RESP; at most one packet in flight.
REQ-017 IDLE: grant = core with valid; both valid -> core indicated by rr_ptr; cN_req_ready = (state==IDLE && grant==N), combinational.
REQ-018 On cN_req_valid && cN_req_ready: capture type/addr/payload/source and port N; rr_ptr <= ~N; state -> ISSUE.
REQ-019 Range check at capture: addr > MEM_BYTES-8 -> no capture, err_range pulse next cycle, stay IDLE, rr_ptr still toggles.
REQ-020 ISSUE: mem_req_valid=1 with captured fields held stable until mem_req_ready; mem_req_valid first high the cycle after acceptance.
REQ-021 ISSUE handshake, write: -> IDLE (no response expected). Read: -> WAIT_RESP, clear timeout counter.
REQ-022 WAIT_RESP, mem_rsp_valid && mem_rsp_dest == captured source: cP_rsp_valid=1, cP_rsp_data=mem_rsp_data next cycle, P = captured port; -> IDLE.
REQ-023 WAIT_RESP, mem_rsp_valid with dest mismatch: response dropped, err_dest pulse, stay WAIT_RESP.
REQ-024 WAIT_RESP, counter increments per cycle without a valid response; at count==TIMEOUT: err_timeout pulse, no core response, -> IDLE.
REQ-025 mem_rsp_valid outside WAIT_RESP: ignored, err_dest pulse.
REQ-026 Response and new-request acceptance are never in the same cycle; a new request is accepted no earlier than the cycle after return to IDLE.
REQ-027 Core-side rsp_valid never asserted for write packets.
REQ-028 Latency, read: accept edge T -> mem_req_valid at T+1; rsp at DRAM response edge +1.

Reset
REQ-029 rst_n low -> state=IDLE, rr_ptr=0 (core 0 priority), counter=0, immediately, asynchronously.
REQ-030 Reset values: all *_valid, *_ready, err_* = 0; mem_req_* fields and cN_rsp_data = 0.
REQ-031 Reset mid-ISSUE or mid-WAIT_RESP discards the in-flight packet; a later DRAM response is handled per REQ-025.
REQ-032 First request accepted no earlier than the first rising edge after rst_n deasserts.

Verification
REQ-033 Both cores valid after reset, reads addr 0x10 / 0x20 -> core 0 granted first, then core 1; each gets its own data.
REQ-034 Core 1 write addr 0x40 payload 0xDEADBEEF_CAFEF00D, mem_req_ready held low 5 cycles -> fields stable, return to IDLE on ready, no rsp pulse.
REQ-035 Read addr MEM_BYTES-7 -> err_range pulse, mem_req_valid never asserted, rr_ptr toggled.
REQ-036 Read source 3, DRAM answers dest 5 then dest 3 -> err_dest once, then core rsp with second data.
REQ-037 Read with no DRAM response, TIMEOUT=8 -> err_timeout 8 cycles after entering WAIT_RESP, FSM back to IDLE.
REQ-038 rst_n pulsed low during WAIT_RESP -> all outputs 0 at once; late mem_rsp_valid -> err_dest only.
